// File: rtl/csr_trap_seq.sv
// Trap/mret sequencer driving one initiator port of the machine-mode CSR file.
// Optional macro CSR_TRAP_MTVAL_EN adds the mtval write to the trap sequence.
module csr_trap_seq #(
  parameter int unsigned MSTATUS_IDX = 0,
  parameter int unsigned MTVEC_IDX   = 1,
  parameter int unsigned MEPC_IDX    = 2,
  parameter int unsigned MCAUSE_IDX  = 3,
  parameter int unsigned MTVAL_IDX   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_valid,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        mret_valid,
  output logic        req_ready,
  output logic        busy,
  output logic [11:0] csr_addr,
  output logic        csr_we,
  output logic [31:0] csr_wd,
  input  logic [31:0] csr_rd,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_T_MEPC    = 4'd1;
  localparam logic [3:0] S_T_MCAUSE  = 4'd2;
`ifdef CSR_TRAP_MTVAL_EN
  localparam logic [3:0] S_T_MTVAL   = 4'd3;
`endif
  localparam logic [3:0] S_T_MSTATUS = 4'd4;
  localparam logic [3:0] S_T_MTVEC   = 4'd5;
  localparam logic [3:0] S_M_MSTATUS = 4'd6;
  localparam logic [3:0] S_M_MEPC    = 4'd7;
  localparam logic [3:0] S_REDIR     = 4'd8;

  logic [3:0]  state, state_nxt;
  logic [29:0] pc_q;
  logic [31:0] cause_q;
  logic [31:0] target_q, target_nxt;
  logic        unused_pc_lsb;

  assign unused_pc_lsb = ^trap_pc[1:0];

`ifdef CSR_TRAP_MTVAL_EN
  logic [31:0] tval_q;
`else
  logic        unused_tval;
  assign unused_tval = ^trap_tval;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Operand latch on trap acceptance and redirect target register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= '0;
      cause_q  <= '0;
      target_q <= '0;
`ifdef CSR_TRAP_MTVAL_EN
      tval_q   <= '0;
`endif
    end else begin
      if (state == S_IDLE && trap_valid) begin
        pc_q    <= trap_pc[31:2];
        cause_q <= trap_cause;
`ifdef CSR_TRAP_MTVAL_EN
        tval_q  <= trap_tval;
`endif
      end
      target_q <= target_nxt;
    end
  end

  // Next state and CSR port drive; mstatus RMW uses the same-cycle read data
  always_comb begin
    state_nxt  = state;
    target_nxt = target_q;
    csr_addr   = '0;
    csr_we     = 1'b0;
    csr_wd     = '0;
    case (state)
      S_IDLE: begin
        if (trap_valid)      state_nxt = S_T_MEPC;
        else if (mret_valid) state_nxt = S_M_MSTATUS;
      end
      S_T_MEPC: begin
        csr_addr  = 12'(MEPC_IDX);
        csr_we    = 1'b1;
        csr_wd    = {pc_q, 2'b00};
        state_nxt = S_T_MCAUSE;
      end
      S_T_MCAUSE: begin
        csr_addr  = 12'(MCAUSE_IDX);
        csr_we    = 1'b1;
        csr_wd    = cause_q;
`ifdef CSR_TRAP_MTVAL_EN
        state_nxt = S_T_MTVAL;
`else
        state_nxt = S_T_MSTATUS;
`endif
      end
`ifdef CSR_TRAP_MTVAL_EN
      S_T_MTVAL: begin
        csr_addr  = 12'(MTVAL_IDX);
        csr_we    = 1'b1;
        csr_wd    = tval_q;
        state_nxt = S_T_MSTATUS;
      end
`endif
      S_T_MSTATUS: begin
        csr_addr      = 12'(MSTATUS_IDX);
        csr_we        = 1'b1;
        csr_wd        = csr_rd;
        csr_wd[7]     = csr_rd[3];
        csr_wd[3]     = 1'b0;
        csr_wd[12:11] = 2'b11;
        state_nxt     = S_T_MTVEC;
      end
      S_T_MTVEC: begin
        csr_addr = 12'(MTVEC_IDX);
        // Only mode 1 with an interrupt cause is vectored; modes 2/3 act direct
        if (csr_rd[1:0] == 2'b01 && cause_q[31])
          target_nxt = {csr_rd[31:2], 2'b00} + {cause_q[29:0], 2'b00};
        else
          target_nxt = {csr_rd[31:2], 2'b00};
        state_nxt = S_REDIR;
      end
      S_M_MSTATUS: begin
        csr_addr      = 12'(MSTATUS_IDX);
        csr_we        = 1'b1;
        csr_wd        = csr_rd;
        csr_wd[3]     = csr_rd[7];
        csr_wd[7]     = 1'b1;
        csr_wd[12:11] = 2'b11;
        state_nxt     = S_M_MEPC;
      end
      S_M_MEPC: begin
        csr_addr   = 12'(MEPC_IDX);
        target_nxt = {csr_rd[31:2], 2'b00};
        state_nxt  = S_REDIR;
      end
      S_REDIR: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy           = (state != S_IDLE);
  assign req_ready      = ~busy;
  assign redirect_valid = (state == S_REDIR);
  assign redirect_pc    = target_q;

endmodule

// File: doc/csr_trap_seq.md
# csr_trap_seq

Trap/return sequencer acting as the initiator on one port of the machine-mode CSR register file. On an exception/interrupt request it writes `mepc`, `mcause` (optionally `mtval`) and updates `mstatus`, then reads `mtvec` and issues a PC redirect. On `mret` it restores `mstatus` and redirects to `mepc`. It sits between the core's pipeline control and the CSR file, and issues one CSR access per cycle.

## Interface
- `MSTATUS_IDX`, default 0: CSR file index of `mstatus`.
- `MTVEC_IDX`, default 1: index of `mtvec`.
- `MEPC_IDX`, default 2: index of `mepc`.
- `MCAUSE_IDX`, default 3: index of `mcause`.
- `MTVAL_IDX`, default 4: index of `mtval`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `trap_valid` in 1: trap request.
- `trap_cause` in 32: mcause value; bit 31 set means interrupt.
- `trap_pc` in 32: PC of the faulting or interrupted instruction.
- `trap_tval` in 32: trap value.
- `mret_valid` in 1: `mret` request.
- `req_ready` out 1: requests are accepted; equals `~busy`, combinational.
- `busy` out 1: sequence in progress.
- `csr_addr` out 12: CSR index.
- `csr_we` out 1: write enable.
- `csr_wd` out 32: write data.
- `csr_rd` in 32: read data, combinational from `csr_addr`.
- `redirect_valid` out 1: one-cycle pulse.
- `redirect_pc` out 32: redirect target; valid while `redirect_valid` is high.

## Operation
- **States:** IDLE, T_MEPC, T_MCAUSE, T_MTVAL (only with the macro), T_MSTATUS, T_MTVEC, M_MSTATUS, M_MEPC, REDIR.
- **IDLE:**
  - If `trap_valid`, latch `trap_pc`/`cause`/`tval` and go to T_MEPC.
  - Else if `mret_valid`, go to M_MSTATUS.
  - Trap wins when both are high in the same cycle; the `mret` is dropped, and the requester must re-present it.
- **Trap path:**
  - T_MEPC: write `mepc = {pc[31:2],2'b00}`.
  - T_MCAUSE: write the latched cause.
  - T_MTVAL: write the latched tval.
  - T_MSTATUS: read-modify-write in a single cycle, with `csr_addr=MSTATUS_IDX`, `csr_we=1`, `csr_wd` derived from `csr_rd`:
    - MPIE[7] ← MIE[3]
    - MIE[3] ← 0
    - MPP[12:11] ← 2'b11
    - all other bits unchanged
  - T_MTVEC: read `mtvec` and register the target, then go to REDIR.
    - base = `{mtvec[31:2],2'b00}`.
    - If `mtvec[1:0]==2'b01` and cause[31]=1, target = base + (cause[30:0] << 2), truncated to 32 bits.
    - Otherwise target = base. Mode values 2 and 3 are treated as direct.
- **Mret path:**
  - M_MSTATUS: read-modify-write:
    - MIE ← MPIE
    - MPIE ← 1
    - MPP ← 2'b11
  - M_MEPC: read `mepc`; target = `{mepc[31:2],2'b00}`; go to REDIR.
- **REDIR:** `redirect_valid`=1, `redirect_pc`=target; go to IDLE.
- **Idle-state outputs:** in IDLE, REDIR and read-only states, `csr_we`=0. In IDLE and REDIR, `csr_addr`=0 and `csr_wd`=0.
- **Requests while busy:** ignored; they are not queued.
- **Reset mid-sequence:** return to IDLE immediately with no redirect. CSR writes already committed stay; no rollback.

## Timing
- **Reset values:**
  - state IDLE
  - `busy`=0, `req_ready`=1
  - `csr_we`=0, `csr_addr`=0, `csr_wd`=0
  - `redirect_valid`=0, `redirect_pc`=0
  - latched operands 0
- **Trap latency:** request accepted at edge N. CSR writes occur at the edges ending cycles N+1 (mepc), N+2 (mcause), N+3 (mstatus). `mtvec` is read in N+4. `redirect_valid` is high in N+5.
  - With the macro, mtval is written at N+3, mstatus at N+4, `mtvec` read in N+5, and the redirect is in N+6.
- **Mret latency:** mstatus written at N+1, mepc read in N+2, redirect in N+3.
- **busy:** high from the cycle after acceptance through the REDIR cycle inclusive. A new request is accepted in the cycle after REDIR.
- **Back-to-back:** a trap immediately following another trap overwrites MPIE with MIE=0. This is legal and must not be special-cased.

## Configuration
- Macro: `CSR_TRAP_MTVAL_EN`.
- **Defined:** the T_MTVAL state exists; `mtval` is written with `trap_tval` and trap latency is 6.
- **Undefined:** T_MTVAL, the tval latch and `trap_tval` usage are removed. The port remains but is ignored; `MTVAL_IDX` is never driven and trap latency is 5.

## Test plan
- **Direct trap:** mtvec=0x0000_0100, mstatus=0x0000_0008; trap cause=2, pc=0x0000_0044 -> mepc=0x44, mcause=2, mstatus=0x0000_1880, `redirect_pc`=0x100 pulsed once at N+5 (N+6 with the macro).
- **Vectored interrupt:** mtvec=0x0000_0201, cause=0x8000_0007 -> `redirect_pc`=0x0000_021C. Same mtvec with cause=5 (exception) -> 0x0000_0200.
- **Mret:** mstatus=0x0000_1880, mepc=0x0000_0046 -> mstatus=0x0000_1888, `redirect_pc`=0x0000_0044 at N+3, `busy` low at N+4.
- **Simultaneous and while-busy requests:** `trap_valid` and `mret_valid` asserted together -> trap sequence only. Pulse `mret_valid` during `busy` -> ignored, no second redirect.
- **Reset mid-operation:** assert `rst` in T_MCAUSE -> all outputs at reset values immediately; mepc holds the new value, mcause unchanged; no `redirect_valid`.
- **Macro:** with `CSR_TRAP_MTVAL_EN`, tval=0xDEAD_BEEF -> mtval=0xDEAD_BEEF. Without it, the `MTVAL_IDX` entry is untouched.
